// File: rtl/lsu_byte_sequencer_if.sv
// Request/response and byte-memory signal bundle for lsu_byte_sequencer.
// Latency: none, wiring only. Backpressure: req_ready gates requests, mem_ack stalls bytes.
// Ports: req_* from execute, resp_* back to execute, mem_* to/from the byte-wide data RAM.
interface lsu_byte_sequencer_if #(
  parameter int MEM_AW = 7
);
  logic              req_valid;
  logic              req_ready;
  logic              req_is_ld;
  logic              req_is_st;
  logic [2:0]        req_variant;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_req;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_ack;

  // Sequencer view.
  modport slave (
    input  req_valid, req_is_ld, req_is_st, req_variant, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  // Execute stage / memory side view.
  modport master (
    output req_valid, req_is_ld, req_is_st, req_variant, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/lsu_byte_sequencer.sv
// Splits one load/store into 1, 2 or 4 big-endian byte transactions and returns an extended result.
// Latency: N+1 cycles from accept to resp_valid with a zero-wait RAM, +1 per mem_ack-low cycle; illegal requests answer after 1.
// Backpressure: req_ready only in IDLE (one request outstanding); mem_ack stalls bytes; responses cannot be stalled.
// Ports: clk, reset (async, active-high), bus (lsu_byte_sequencer_if.slave carrying req_*, resp_*, mem_*).
module lsu_byte_sequencer #(
  parameter int MEM_AW = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  lsu_byte_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q,  addr_d;   // full address kept for the illegal-request echo
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] asm_q,   asm_d;    // load bytes shifted in MSB-first
  logic [1:0]  last_q,  last_d;   // index of the final byte: N-1
  logic [1:0]  k_q,     k_d;      // current byte index
  logic        is_st_q, is_st_d;
  logic        sgn_q,   sgn_d;    // sign-extend the load result
  logic        err_q,   err_d;

  // Store bytes go out MSB-first within the N-byte field.
  logic [1:0]  byte_idx;
  assign byte_idx = last_q - k_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      asm_q   <= '0;
      last_q  <= '0;
      k_q     <= '0;
      is_st_q <= 1'b0;
      sgn_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      asm_q   <= asm_d;
      last_q  <= last_d;
      k_q     <= k_d;
      is_st_q <= is_st_d;
      sgn_q   <= sgn_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    asm_d          = asm_q;
    last_d         = last_q;
    k_d            = k_q;
    is_st_d        = is_st_q;
    sgn_d          = sgn_q;
    err_d          = err_q;

    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = '0;
    bus.resp_err   = 1'b0;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;

    case (state_q)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          addr_d = bus.req_addr;
          if (bus.req_is_ld ^ bus.req_is_st) begin
            wdata_d = bus.req_wdata;
            is_st_d = bus.req_is_st;
            err_d   = 1'b0;
            k_d     = 2'd0;
            asm_d   = '0;
            sgn_d   = 1'b0;
            if (bus.req_is_ld) begin
              case (bus.req_variant)
                3'b000:  begin last_d = 2'd0; sgn_d = 1'b1; end  // LB
                3'b001:  begin last_d = 2'd1; sgn_d = 1'b1; end  // LH
                3'b100:  last_d = 2'd1;                          // LHU
                3'b101:  last_d = 2'd0;                          // LBU
                default: last_d = 2'd3;                          // LW
              endcase
            end else begin
              case (bus.req_variant)
                3'b000:  last_d = 2'd0;                          // SB
                3'b001:  last_d = 2'd1;                          // SH
                default: last_d = 2'd3;                          // SW
              endcase
            end
            state_d = S_XFER;
          end else begin
            // Neither or both directions: answer with an error, no memory access.
            err_d   = 1'b1;
            state_d = S_RESP;
          end
        end
      end

      S_XFER: begin
        bus.mem_req  = 1'b1;
        // Adds in MEM_AW bits so a crossing of the top address wraps to 0.
        bus.mem_addr = addr_q[MEM_AW-1:0] + MEM_AW'(k_q);
        bus.mem_we   = is_st_q;
        if (is_st_q) begin
          bus.mem_wdata = wdata_q[{byte_idx, 3'b000} +: 8];
        end
        if (bus.mem_ack) begin
          if (!is_st_q) begin
            asm_d = {asm_q[23:0], bus.mem_rdata};
          end
          k_d = k_q + 2'd1;
          if (k_q == last_q) begin
            state_d = S_RESP;
          end
        end
      end

      S_RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = err_q;
        if (err_q) begin
          bus.resp_rdata = addr_q;
        end else if (!is_st_q) begin
          case (last_q)
            2'd0:    bus.resp_rdata = {{24{sgn_q & asm_q[7]}},  asm_q[7:0]};
            2'd1:    bus.resp_rdata = {{16{sgn_q & asm_q[15]}}, asm_q[15:0]};
            default: bus.resp_rdata = asm_q;
          endcase
        end
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// Self-checking bench for lsu_byte_sequencer: scoreboarded responses and byte transactions against a byte RAM model.
// Latency: responses checked against N*(wait+1) cycles after accept.
// Backpressure: RAM model can insert a fixed number of mem_ack-low cycles per byte.
module tb_lsu_byte_sequencer;
  localparam int MEM_AW = 7;

  logic clk;
  logic reset;

  lsu_byte_sequencer_if #(.MEM_AW(MEM_AW)) bif ();

  lsu_byte_sequencer #(.MEM_AW(MEM_AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          lat;
  } resp_t;

  typedef struct {
    logic [MEM_AW-1:0] addr;
    logic              we;
    logic [7:0]        wdata;
  } mtx_t;

  resp_t      sb_resp[$];
  mtx_t       sb_mem[$];
  logic [7:0] mem [0:(1<<MEM_AW)-1];
  bit         mem_init = 1'b0;
  int         wait_cycles = 0;
  int         wcnt = 0;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Byte RAM: byte[i]=i at start, optional fixed wait states per byte.
  assign bif.mem_rdata = mem[bif.mem_addr];
  assign bif.mem_ack   = (wait_cycles == 0) ? 1'b1 : (wcnt >= wait_cycles);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!mem_init) begin
      for (int i = 0; i < (1 << MEM_AW); i++) mem[i] <= 8'(i);
      mem_init <= 1'b1;
    end else if (bif.mem_req && bif.mem_ack && bif.mem_we) begin
      mem[bif.mem_addr] <= bif.mem_wdata;
    end
    if (bif.mem_req && !bif.mem_ack) wcnt <= wcnt + 1;
    else                             wcnt <= 0;
  end

  // Monitor: byte transactions (checked every cycle mem_req is up) and responses.
  always @(negedge clk) begin
    mtx_t  m;
    resp_t r;
    if (!reset) begin
      if (bif.mem_req) begin
        if (sb_mem.size() == 0) begin
          check_eq("mem_req_unexpected", 32'(bif.mem_req), 32'd0);
        end else begin
          m = sb_mem[0];
          check_eq("mem_addr", 32'(bif.mem_addr), 32'(m.addr));
          check_eq("mem_we", 32'(bif.mem_we), 32'(m.we));
          if (m.we) check_eq("mem_wdata", 32'(bif.mem_wdata), 32'(m.wdata));
          if (bif.mem_ack) void'(sb_mem.pop_front());
        end
      end
      if (bif.resp_valid) begin
        if (sb_resp.size() == 0) begin
          check_eq("resp_unexpected", 32'(bif.resp_valid), 32'd0);
        end else begin
          r = sb_resp.pop_front();
          check_eq("resp_rdata", bif.resp_rdata, r.rdata);
          check_eq("resp_err", 32'(bif.resp_err), 32'(r.err));
          check_eq("resp_latency", 32'(cyc - r.acc), 32'(r.lat));
        end
      end
    end
  end

  function automatic int nbytes(input logic ld, input logic st, input logic [2:0] vrnt);
    if (ld == st) return 0;
    if (ld) begin
      case (vrnt)
        3'b000, 3'b101: return 1;
        3'b001, 3'b100: return 2;
        default:        return 4;
      endcase
    end
    case (vrnt)
      3'b000:  return 1;
      3'b001:  return 2;
      default: return 4;
    endcase
  endfunction

  task automatic issue(input logic ld, input logic st, input logic [2:0] vrnt,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err);
    int    n;
    int    i;
    mtx_t  m;
    resp_t r;
    logic [31:0] sh;
    @(negedge clk);
    for (i = 0; i < 200 && !bif.req_ready; i++) @(negedge clk);
    if (!bif.req_ready) begin
      check_eq("req_ready_timeout", 32'(bif.req_ready), 32'd1);
      return;
    end
    bif.req_valid   = 1'b1;
    bif.req_is_ld   = ld;
    bif.req_is_st   = st;
    bif.req_variant = vrnt;
    bif.req_addr    = addr;
    bif.req_wdata   = wdata;
    n = nbytes(ld, st, vrnt);
    for (int k = 0; k < n; k++) begin
      m.addr  = MEM_AW'(addr + 32'(k));
      m.we    = st;
      sh      = wdata >> (8 * (n - 1 - k));
      m.wdata = sh[7:0];
      sb_mem.push_back(m);
    end
    @(posedge clk);
    #1;
    r.rdata = exp_rdata;
    r.err   = exp_err;
    r.acc   = cyc;
    r.lat   = n * (wait_cycles + 1);
    sb_resp.push_back(r);
    bif.req_valid = 1'b0;
    bif.req_is_ld = 1'b0;
    bif.req_is_st = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && sb_resp.size() != 0; i++) @(negedge clk);
    check_eq(tag, 32'(sb_resp.size()), 32'd0);
  endtask

  initial begin
    reset           = 1'b1;
    bif.req_valid   = 1'b0;
    bif.req_is_ld   = 1'b0;
    bif.req_is_st   = 1'b0;
    bif.req_variant = 3'b000;
    bif.req_addr    = '0;
    bif.req_wdata   = '0;
    repeat (3) @(negedge clk);

    check_eq("rst_req_ready",  32'(bif.req_ready),  32'd1);
    check_eq("rst_resp_valid", 32'(bif.resp_valid), 32'd0);
    check_eq("rst_resp_rdata", bif.resp_rdata,       32'd0);
    check_eq("rst_resp_err",   32'(bif.resp_err),   32'd0);
    check_eq("rst_mem_req",    32'(bif.mem_req),    32'd0);
    check_eq("rst_mem_we",     32'(bif.mem_we),     32'd0);
    check_eq("rst_mem_addr",   32'(bif.mem_addr),   32'd0);
    check_eq("rst_mem_wdata",  32'(bif.mem_wdata),  32'd0);
    reset = 1'b0;

    // Loads from the identity-initialised RAM; upper address bits ignored.
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0, 32'h1011_1213, 1'b0);
    issue(1'b1, 1'b0, 3'b010, 32'h1234_5690, 32'h0, 32'h1011_1213, 1'b0);
    issue(1'b1, 1'b0, 3'b111, 32'h0000_0010, 32'h0, 32'h1011_1213, 1'b0);

    // Byte and halfword extension.
    issue(1'b0, 1'b1, 3'b000, 32'h04, 32'h0000_00F0, 32'h0, 1'b0);
    issue(1'b1, 1'b0, 3'b000, 32'h04, 32'h0, 32'hFFFF_FFF0, 1'b0);
    issue(1'b1, 1'b0, 3'b101, 32'h04, 32'h0, 32'h0000_00F0, 1'b0);
    issue(1'b0, 1'b1, 3'b001, 32'h04, 32'h0000_8001, 32'h0, 1'b0);
    issue(1'b1, 1'b0, 3'b001, 32'h04, 32'h0, 32'hFFFF_8001, 1'b0);
    issue(1'b1, 1'b0, 3'b100, 32'h04, 32'h0, 32'h0000_8001, 1'b0);

    // Halfword crossing the top of memory.
    issue(1'b0, 1'b1, 3'b001, 32'h7F, 32'h0000_ABCD, 32'h0, 1'b0);
    issue(1'b1, 1'b0, 3'b100, 32'h7F, 32'h0, 32'h0000_ABCD, 1'b0);
    drain("drain_wrap");
    check_eq("mem_7f", 32'(mem[7'h7F]), 32'hAB);
    check_eq("mem_00", 32'(mem[7'h00]), 32'hCD);

    // Word store with two wait cycles per byte.
    wait_cycles = 2;
    issue(1'b0, 1'b1, 3'b010, 32'h20, 32'h1122_3344, 32'h0, 1'b0);
    drain("drain_sw_wait");
    wait_cycles = 0;
    check_eq("mem_20", 32'(mem[7'h20]), 32'h11);
    check_eq("mem_21", 32'(mem[7'h21]), 32'h22);
    check_eq("mem_22", 32'(mem[7'h22]), 32'h33);
    check_eq("mem_23", 32'(mem[7'h23]), 32'h44);

    // Illegal direction codes.
    issue(1'b1, 1'b1, 3'b000, 32'h55, 32'h0, 32'h0000_0055, 1'b1);
    issue(1'b0, 1'b0, 3'b000, 32'h55, 32'h0, 32'h0000_0055, 1'b1);

    // Reset after two bytes of a word load.
    issue(1'b1, 1'b0, 3'b010, 32'h30, 32'h0, 32'h3031_3233, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    sb_resp.delete();
    sb_mem.delete();
    check_eq("mid_rst_mem_req",    32'(bif.mem_req),    32'd0);
    check_eq("mid_rst_mem_addr",   32'(bif.mem_addr),   32'd0);
    check_eq("mid_rst_resp_valid", 32'(bif.resp_valid), 32'd0);
    check_eq("mid_rst_req_ready",  32'(bif.req_ready),  32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("post_rst_req_ready", 32'(bif.req_ready), 32'd1);
    issue(1'b1, 1'b0, 3'b000, 32'h31, 32'h0, 32'h0000_0031, 1'b0);
    drain("drain_final");
    check_eq("mem_left", 32'(sb_mem.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/lsu_byte_sequencer.md
# lsu_byte_sequencer

Load/store sequencer between the execute stage and the byte-wide data RAM. It accepts one load or store request at a time and splits it into 1, 2 or 4 single-byte memory transactions over a req/ack handshake. Multi-byte data is big-endian: the lowest address holds the most significant byte. Load results are sign- or zero-extended according to the variant code and returned with a one-cycle response strobe.

## Interface

Parameters:
- MEM_AW, 7: byte address width of the data RAM (128 bytes). Byte addresses wrap modulo 2^MEM_AW.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  sequencer idle and able to accept a request
- req_is_ld  in  1  load request
- req_is_st  in  1  store request
- req_variant  in  3  load: 000 LB, 001 LH, 010 LW, 100 LHU, 101 LBU, other LW; store: 000 SB, 001 SH, 010 SW, other SW
- req_addr  in  32  byte address; only [MEM_AW-1:0] is used for memory
- req_wdata  in  32  store data; the low 8, 16 or 32 bits are used
- resp_valid  out  1  one-cycle response strobe
- resp_rdata  out  32  extended load data; 0 for stores; req_addr for illegal requests
- resp_err  out  1  qualifies resp_valid; set when is_ld and is_st are both 0 or both 1
- mem_req  out  1  byte transaction request
- mem_we  out  1  1 = byte write, 0 = byte read
- mem_addr  out  MEM_AW  byte address
- mem_wdata  out  8  write byte
- mem_rdata  in  8  read byte, valid when mem_ack is high
- mem_ack  in  1  transaction complete; only meaningful while mem_req is high

## Operation

- States: IDLE, XFER, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid with exactly one of is_ld/is_st: latch addr, wdata, variant and direction; set byte count N (1, 2 or 4); clear index k and the assembly register; go to XFER.
  - On req_valid with neither or both set: latch the error and req_addr; go to RESP with no memory access.
- XFER:
  - mem_req=1 and mem_addr=(base+k) mod 2^MEM_AW.
  - mem_we=1 for stores. mem_wdata is the store byte k counted from the MSB of the N-byte field. Example: SH sends wdata[15:8] then wdata[7:0].
  - On mem_ack:
    - For a load, shift mem_rdata into the LSB of the assembly register.
    - Increment k. If k+1==N, go to RESP; otherwise stay in XFER with the next address.
- RESP:
  - resp_valid=1 for exactly one cycle, then go to IDLE.
  - Load extension:
    - LB: sign-extend bit 7.
    - LH: sign-extend bit 15.
    - LBU/LHU: zero-extend.
    - LW: no extension.
  - resp_err=1 only for illegal requests.
- Responses have no backpressure. A new request is accepted only in IDLE, so at most one request is outstanding.
- Address wrap: a multi-byte access that crosses 2^MEM_AW−1 continues at address 0.
- req_addr bits above MEM_AW-1 are ignored and are not flagged as an error.

## Timing

- Reset values: state IDLE; req_ready=1; all other outputs 0 (resp_valid, resp_rdata, resp_err, mem_req, mem_we, mem_addr, mem_wdata).
- Accept at edge T. mem_req rises after T. mem_addr, mem_we and mem_wdata are stable until the edge where mem_ack is sampled high.
- Zero-wait memory (mem_ack tied high): one byte per cycle. resp_valid is high in cycle T+N+1, so LW responds at T+5 and LB at T+2.
- An illegal request responds in cycle T+1.
- Each cycle of mem_ack low while mem_req is high adds one cycle of latency.
- mem_ack high while mem_req is low is ignored.
- mem_req stays high across consecutive bytes of one request and drops in RESP.
- Reset asserted mid-transfer: immediate return to IDLE and reset values. The partial access is abandoned; bytes already written stay written. No response is issued.

## Test plan

- Memory model byte[i]=i with ack tied high; LW at 0x10 -> mem_addr sequence 0x10..0x13, resp_rdata=0x10111213, resp_valid in cycle T+5.
- SB 0x000000F0 at 0x04, then LB at 0x04 -> 0xFFFFFFF0; LBU at 0x04 -> 0x000000F0; LH at 0x04 after SH 0x8001 -> 0xFFFF8001; LHU at 0x04 -> 0x00008001.
- SH 0x0000ABCD at 0x7F -> writes 0xAB at 0x7F and 0xCD at 0x00 (wrap); a following LHU at 0x7F -> 0x0000ABCD.
- mem_ack delayed 2 cycles per byte on SW 0x11223344 at 0x20 -> mem_addr/mem_wdata held stable while waiting, bytes 11,22,33,44 at 0x20..0x23, resp_valid at T+13 with rdata=0.
- req_is_ld=req_is_st=1 with addr 0x55 -> no mem_req, resp_valid at T+1 with resp_err=1 and resp_rdata=0x00000055; the same for both low.
- Reset pulsed after 2 bytes of an LW -> all outputs 0 immediately, no resp_valid, req_ready=1 after release; next LB accepted normally.
